// File: rtl/mac_array_ctrl.sv
// Per-kernel sequencer for the weight-stationary MAC array: array reset, weight fill and
// load, settle gap, activation fill, execute and OFIFO drain, once per kernel index.
module mac_array_ctrl #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned len_kij = 9,
  parameter int unsigned len_nij = 36,
  parameter int unsigned w_aw    = 7,
  parameter int unsigned x_aw    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            w_ren,
  output logic [w_aw-1:0] w_addr,
  output logic            x_ren,
  output logic [x_aw-1:0] x_addr,
  output logic            l0_wr,
  output logic            l0_rd,
  input  logic            l0_full,
  output logic            array_rst,
  output logic [1:0]      inst_w,
  input  logic            ofifo_valid,
  output logic            ofifo_rd,
  output logic [3:0]      kij_idx,
  output logic [3:0]      state_dbg
);

  localparam int unsigned CMAX = (row + col > len_nij) ? row + col : len_nij;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(row + col - 1);
  localparam logic [CW-1:0] NIJ_LAST = CW'(len_nij - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    KIJ_LAST = 4'(len_kij - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARST  = 4'd1,
    WFILL = 4'd2,
    WLOAD = 4'd3,
    WGAP  = 4'd4,
    XFILL = 4'd5,
    EXEC  = 4'd6,
    DRAIN = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fill_done, fill_done_nxt;
  logic [3:0]    kij_nxt;

  // Handshakes: an SRAM read is issued only when l0_full is low (the data lands in L0 one
  // cycle later, so one free entry suffices); an OFIFO row is consumed in exactly the
  // cycles where ofifo_valid and ofifo_rd are both high. Neither side ever times out.

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_done <= 1'b0;
      kij_idx   <= '0;
      l0_wr     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fill_done <= fill_done_nxt;
      kij_idx   <= kij_nxt;
      l0_wr     <= w_ren | x_ren;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    fill_done_nxt = fill_done;
    kij_nxt       = kij_idx;
    w_ren         = 1'b0;
    x_ren         = 1'b0;
    l0_rd         = 1'b0;
    array_rst     = 1'b0;
    inst_w        = 2'b00;
    ofifo_rd      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = ARST;
          kij_nxt       = '0;
          cnt_nxt       = '0;
          fill_done_nxt = 1'b0;
        end
      end
      ARST: begin
        array_rst     = 1'b1;
        state_nxt     = WFILL;
        cnt_nxt       = '0;
        fill_done_nxt = 1'b0;
      end
      // cnt holds at the last index once all reads are out, so the address never
      // steps past the final weight of the last kernel.
      WFILL: begin
        if (fill_done) begin
          state_nxt     = WLOAD;
          cnt_nxt       = '0;
          fill_done_nxt = 1'b0;
        end else if (!l0_full) begin
          w_ren = 1'b1;
          if (cnt == COL_LAST) fill_done_nxt = 1'b1;
          else                 cnt_nxt       = cnt + CNT_ONE;
        end
      end
      WLOAD: begin
        l0_rd  = 1'b1;
        inst_w = 2'b01;
        if (cnt == COL_LAST) begin
          state_nxt = WGAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WGAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = XFILL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      XFILL: begin
        if (fill_done) begin
          state_nxt     = EXEC;
          cnt_nxt       = '0;
          fill_done_nxt = 1'b0;
        end else if (!l0_full) begin
          x_ren = 1'b1;
          if (cnt == NIJ_LAST) fill_done_nxt = 1'b1;
          else                 cnt_nxt       = cnt + CNT_ONE;
        end
      end
      EXEC: begin
        l0_rd  = 1'b1;
        inst_w = 2'b10;
        if (cnt == NIJ_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DRAIN: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          if (cnt == NIJ_LAST) begin
            cnt_nxt = '0;
            if (kij_idx == KIJ_LAST) begin
              state_nxt = DONE;
            end else begin
              kij_nxt   = kij_idx + 4'd1;
              state_nxt = ARST;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign w_addr    = (state == WFILL) ? w_aw'(32'(kij_idx) * col + 32'(cnt)) : '0;
  assign x_addr    = (state == XFILL) ? x_aw'(cnt) : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed and randomized checks of mac_array_ctrl against a phase-timeline model and
// expected address/kernel queues built from the sequencing rules.
module tb_mac_array_ctrl;

  localparam int ROW = 2;
  localparam int COL = 2;
  localparam int KIJ = 2;
  localparam int NIJ = 4;
  localparam int PASS_LEN = 1 + (COL + 1) + COL + (ROW + COL) + (NIJ + 1) + NIJ + NIJ;
  localparam int RUN_LEN  = KIJ * PASS_LEN;

  logic       clk = 1'b0;
  logic       reset, start, l0_full, ofifo_valid;
  logic       busy, done, w_ren, x_ren, l0_wr, l0_rd, array_rst, ofifo_rd;
  logic [6:0] w_addr;
  logic [5:0] x_addr;
  logic [1:0] inst_w;
  logic [3:0] kij_idx, state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w[$];
  logic [31:0] exp_x[$];
  logic [31:0] exp_k[$];
  logic [1:0]  lg_inst[$];
  logic        lg_wren[$], lg_xren[$], lg_l0wr[$], lg_ofrd[$], lg_arst[$];
  logic [5:0]  lg_xaddr[$];
  logic [3:0]  lg_kij[$];
  logic        prev_ren;
  int          done_at, n01, n10, narst;

  mac_array_ctrl #(
    .row(ROW), .col(COL), .len_kij(KIJ), .len_nij(NIJ), .w_aw(7), .x_aw(6)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .w_ren(w_ren), .w_addr(w_addr), .x_ren(x_ren), .x_addr(x_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full), .array_rst(array_rst),
    .inst_w(inst_w), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .kij_idx(kij_idx), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, w_ren, w_addr, x_ren, x_addr, l0_wr, l0_rd,
                array_rst, inst_w, ofifo_rd, kij_idx});
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, check invariants and log.
  task automatic tick(input logic f, input logic v, input logic s);
    @(negedge clk);
    l0_full = f; ofifo_valid = v; start = s;
    #1;
    check("excl_ren", 32'(w_ren & x_ren), 0);
    check("excl_l0", 32'(l0_wr & l0_rd), 0);
    check("inst_11", 32'(inst_w == 2'b11), 0);
    check("l0wr_lag", 32'(l0_wr), 32'(prev_ren));
    check("ren_full", 32'((w_ren | x_ren) & l0_full), 0);
    check("rd_valid", 32'(ofifo_rd & ~ofifo_valid), 0);
    if (w_ren) begin
      if (exp_w.size() == 0) check("w_extra", 1, 0);
      else check("w_addr", 32'(w_addr), exp_w.pop_front());
    end
    if (x_ren) begin
      if (exp_x.size() == 0) check("x_extra", 1, 0);
      else check("x_addr", 32'(x_addr), exp_x.pop_front());
    end
    if (ofifo_rd) begin
      if (exp_k.size() == 0) check("rd_extra", 1, 0);
      else check("rd_kij", 32'(kij_idx), exp_k.pop_front());
    end
    prev_ren = w_ren | x_ren;
    if (inst_w == 2'b01) n01++;
    if (inst_w == 2'b10) n10++;
    if (array_rst) narst++;
    lg_inst.push_back(inst_w);   lg_wren.push_back(w_ren);   lg_xren.push_back(x_ren);
    lg_l0wr.push_back(l0_wr);    lg_ofrd.push_back(ofifo_rd); lg_arst.push_back(array_rst);
    lg_xaddr.push_back(x_addr);  lg_kij.push_back(kij_idx);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_kij", 32'(kij_idx), 1);
    reset = 1'b1;
    #1;
    check("rst_async", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    prev_ren = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check("post_rst_done", 32'(done), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
  endtask

  // Cycle 0 of the logs is the first ARST cycle. ff/fl: l0_full window, vf/vl: ofifo_valid
  // drop window, sa: cycle of a stray start, ra: cycle at which reset aborts the run.
  task automatic run(input bit rnd, input int ff, input int fl, input int vf, input int vl,
                     input int sa, input int ra);
    bit seen;
    exp_w.delete(); exp_x.delete(); exp_k.delete();
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < COL; i++) exp_w.push_back(32'(k * COL + i));
      for (int n = 0; n < NIJ; n++) exp_x.push_back(32'(n));
      for (int n = 0; n < NIJ; n++) exp_k.push_back(32'(k));
    end
    tick(1'b0, 1'b1, 1'b1);
    check("start_idle_busy", 32'(busy), 0);
    lg_inst.delete(); lg_wren.delete(); lg_xren.delete(); lg_l0wr.delete();
    lg_ofrd.delete(); lg_arst.delete(); lg_xaddr.delete(); lg_kij.delete();
    n01 = 0; n10 = 0; narst = 0;
    seen = 1'b0;
    done_at = -1;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (c == ra) begin
        reset_mid();
        return;
      end
      if (rnd) tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'b0);
      else     tick(c >= ff && c < ff + fl, !(c >= vf && c < vf + vl), c == sa);
      if (done) begin
        seen = 1'b1;
        done_at = c;
        check("busy_at_done", 32'(busy), 0);
      end else begin
        check("busy_in_run", 32'(busy), 1);
      end
    end
    if (!seen) check("run_timeout", 0, 1);
    check("w_left", 32'(exp_w.size()), 0);
    check("x_left", 32'(exp_x.size()), 0);
    check("rd_left", 32'(exp_k.size()), 0);
    check("n_load", 32'(n01), 32'(COL * KIJ));
    check("n_exec", 32'(n10), 32'(NIJ * KIJ));
    check("n_arst", 32'(narst), 32'(KIJ));
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check("after_done", 32'(done), 0);
      check("after_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0; prev_ren = 1'b0;
    #2;
    check("rst_outs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("idle_outs", all_outs(), 0);

    // Unstalled run checked cycle by cycle against the phase timeline.
    run(1'b0, -10, 0, -10, 0, -1, -1);
    check("a_done_at", 32'(done_at), 32'(RUN_LEN));
    for (int c = 0; c < RUN_LEN; c++) begin
      r = c % PASS_LEN;
      check("tl_arst", 32'(lg_arst[c]), 32'(r == 0));
      check("tl_wren", 32'(lg_wren[c]), 32'(r >= 1 && r <= 2));
      check("tl_l0wr", 32'(lg_l0wr[c]), 32'((r >= 2 && r <= 3) || (r >= 11 && r <= 14)));
      check("tl_xren", 32'(lg_xren[c]), 32'(r >= 10 && r <= 13));
      check("tl_inst", 32'(lg_inst[c]),
            (r >= 4 && r <= 5) ? 32'd1 : ((r >= 15 && r <= 18) ? 32'd2 : 32'd0));
      check("tl_ofrd", 32'(lg_ofrd[c]), 32'(r >= 19 && r <= 22));
      check("tl_kij", 32'(lg_kij[c]), 32'(c / PASS_LEN));
    end

    // l0_full held three cycles in the first XFILL.
    run(1'b0, 11, 3, -10, 0, -1, -1);
    check("b_done_at", 32'(done_at), 32'(RUN_LEN + 3));
    for (int c = 11; c <= 13; c++) begin
      check("b_xren_stall", 32'(lg_xren[c]), 0);
      check("b_xaddr_hold", 32'(lg_xaddr[c]), 1);
    end
    check("b_xren_resume", 32'(lg_xren[14]), 1);
    check("b_exec_late", 32'(lg_inst[17]), 0);
    check("b_exec_start", 32'(lg_inst[18]), 2);

    // ofifo_valid dropped five cycles in the first DRAIN.
    run(1'b0, -10, 0, 19, 5, -1, -1);
    check("c_done_at", 32'(done_at), 32'(RUN_LEN + 5));
    for (int c = 19; c <= 23; c++) check("c_rd_paused", 32'(lg_ofrd[c]), 0);
    for (int c = 24; c <= 27; c++) check("c_rd_resume", 32'(lg_ofrd[c]), 1);
    check("c_next_arst", 32'(lg_arst[28]), 1);

    // A start pulse during EXEC must not disturb the run.
    run(1'b0, -10, 0, -10, 0, 16, -1);
    check("d_done_at", 32'(done_at), 32'(RUN_LEN));

    // Reset during the WGAP of kernel 1, then a clean run from kernel 0.
    run(1'b0, -10, 0, -10, 0, -1, PASS_LEN + 7);
    run(1'b0, -10, 0, -10, 0, -1, -1);
    check("e_done_at", 32'(done_at), 32'(RUN_LEN));
    check("e_kij0", 32'(lg_kij[0]), 0);
    check("e_arst0", 32'(lg_arst[0]), 1);

    // Random backpressure on both sides.
    for (int k = 0; k < 4; k++) run(1'b1, -10, 0, -10, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
